gpio_in_irq: RTL and testbench

Input-side GPIO peripheral for the SoC. It is the counterpart of the output/LED GPIO block. It synchronizes and debounces WIDTH external switch/button lines and presents the clean levels to the CPU bus. It latches selected edges into a pending register and raises a level interrupt until software clears the pending bits.

---
 rtl/gpio_in_irq.sv | 131 +++++++++++++
 tb/tb_gpio_in_irq.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/gpio_in_irq.sv
// Input-side GPIO: 2-flop synchronizer and per-line debounce FSM for each switch line,
// edge-select pending register with write-1-to-clear, and a masked level interrupt.
module gpio_in_irq #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  input  logic [WIDTH-1:0] edge_rise,
  input  logic [WIDTH-1:0] irq_mask,
  input  logic             clr_valid,
  input  logic [WIDTH-1:0] clr_mask,
  output logic [WIDTH-1:0] sw_value,
  output logic [WIDTH-1:0] pending,
  output logic             irq
);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;
  logic [WIDTH-1:0] sw_value_r;
  logic [WIDTH-1:0] pending_r;
  logic             irq_r;
  state_t           state_r [WIDTH];
  logic [CNT_W-1:0] cnt_r   [WIDTH];

  logic [WIDTH-1:0] ev_s;
  logic [WIDTH-1:0] sw_value_next_s;
  logic [WIDTH-1:0] sel_s;
  logic [WIDTH-1:0] clr_s;

  // Two-stage synchronizer; only sync2_r is consumed downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= {WIDTH{1'b0}};
      sync2_r <= {WIDTH{1'b0}};
    end else begin
      sync1_r <= sw_in;
      sync2_r <= sync1_r;
    end
  end

  // Acceptance strobe and qualified edge select, needed in the same cycle sw_value updates.
  always_comb begin
    ev_s            = {WIDTH{1'b0}};
    sw_value_next_s = sw_value_r;
    sel_s           = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      ev_s[i] = (state_r[i] == ST_SETTLING) && (sync2_r[i] != sw_value_r[i]) &&
                (cnt_r[i] == CNT_LAST);
      if (ev_s[i]) begin
        sw_value_next_s[i] = sync2_r[i];
      end else begin
        sw_value_next_s[i] = sw_value_r[i];
      end
      sel_s[i] = ev_s[i] & (sw_value_next_s[i] == edge_rise[i]);
    end
    if (clr_valid) begin
      clr_s = clr_mask;
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
  end

  // Per-line debounce FSM: a new level must persist CNT_LAST+1 consecutive cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_value_r <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
        state_r[i] <= ST_STABLE;
        cnt_r[i]   <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        case (state_r[i])
          ST_STABLE: begin
            if (sync2_r[i] != sw_value_r[i]) begin
              state_r[i] <= ST_SETTLING;
              cnt_r[i]   <= CNT_ONE;
            end else begin
              state_r[i] <= ST_STABLE;
              cnt_r[i]   <= CNT_ZERO;
            end
          end
          ST_SETTLING: begin
            if (sync2_r[i] == sw_value_r[i]) begin
              state_r[i] <= ST_STABLE;
              cnt_r[i]   <= CNT_ZERO;
            end else if (cnt_r[i] == CNT_LAST) begin
              sw_value_r[i] <= sync2_r[i];
              state_r[i]    <= ST_STABLE;
              cnt_r[i]      <= CNT_ZERO;
            end else begin
              cnt_r[i] <= cnt_r[i] + CNT_ONE;
            end
          end
          default: begin
            state_r[i] <= ST_STABLE;
            cnt_r[i]   <= CNT_ZERO;
          end
        endcase
      end
    end
  end

  // Pending latch (set beats clear) and interrupt level from the current pending state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r <= {WIDTH{1'b0}};
      irq_r     <= 1'b0;
    end else begin
      pending_r <= (pending_r & ~clr_s) | sel_s;
      irq_r     <= |(pending_r & irq_mask);
    end
  end

  assign sw_value = sw_value_r;
  assign pending  = pending_r;
  assign irq      = irq_r;

endmodule

// File: tb/tb_gpio_in_irq.sv
// Randomized + scripted bench for gpio_in_irq; a run-length reference model fills a
// scoreboard queue that an independent monitor drains once per clock.
module tb_gpio_in_irq;

  localparam int WIDTH = 4;
  localparam int DEB   = 4;
  localparam int CNT_W = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] sw_in = 4'b0000;
  logic [WIDTH-1:0] edge_rise = 4'b0000;
  logic [WIDTH-1:0] irq_mask = 4'b0000;
  logic             clr_valid = 1'b0;
  logic [WIDTH-1:0] clr_mask = 4'b0000;
  logic [WIDTH-1:0] sw_value;
  logic [WIDTH-1:0] pending;
  logic             irq;

  gpio_in_irq #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .sw_in(sw_in), .edge_rise(edge_rise), .irq_mask(irq_mask),
    .clr_valid(clr_valid), .clr_mask(clr_mask),
    .sw_value(sw_value), .pending(pending), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] val;
    logic [WIDTH-1:0] pend;
    logic             irq;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cycle = 0;

  // Reference state: line history as two delayed samples and a run length of disagreement.
  logic [WIDTH-1:0] m_s1 = 4'b0000;
  logic [WIDTH-1:0] m_s2 = 4'b0000;
  logic [WIDTH-1:0] m_val = 4'b0000;
  logic [WIDTH-1:0] m_pend = 4'b0000;
  logic             m_irq = 1'b0;
  int               m_run [WIDTH];

  task automatic step(input logic r, input logic [WIDTH-1:0] sw, input logic [WIDTH-1:0] er,
                      input logic [WIDTH-1:0] msk, input logic cv, input logic [WIDTH-1:0] cm);
    logic [WIDTH-1:0] sel;
    logic             irq_next;
    @(negedge clk);
    rst = r; sw_in = sw; edge_rise = er; irq_mask = msk; clr_valid = cv; clr_mask = cm;
    if (r) begin
      m_s1 = 4'b0000; m_s2 = 4'b0000; m_val = 4'b0000; m_pend = 4'b0000; m_irq = 1'b0;
      for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
    end else begin
      sel = 4'b0000;
      irq_next = |(m_pend & msk);
      for (int i = 0; i < WIDTH; i++) begin
        if (m_s2[i] != m_val[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DEB) begin
            m_val[i] = m_s2[i];
            m_run[i] = 0;
            sel[i] = (m_val[i] == er[i]);
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_pend = (m_pend & ~(cv ? cm : 4'b0000)) | sel;
      m_irq = irq_next;
      m_s2 = m_s1;
      m_s1 = sw;
    end
    exp_q.push_back('{val: m_val, pend: m_pend, irq: m_irq});
  endtask

  // Monitor: one expected entry per clock, compared shortly after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (sw_value !== e.val || pending !== e.pend || irq !== e.irq) begin
          miscompares++;
          $display("FAIL outputs cyc%0d: got sw_value=%b pending=%b irq=%b, want sw_value=%b pending=%b irq=%b",
                   cycle, sw_value, pending, irq, e.val, e.pend, e.irq);
        end
      end
    end
  end

  logic [WIDTH-1:0] sw_cur, er_cur, msk_cur, cm_cur;
  logic             cv_cur;
  int               hold [WIDTH];

  initial begin
    for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
    // Reset, then rising edge on line 0 with its interrupt enabled.
    repeat (3) step(1'b1, 4'b0000, 4'b0001, 4'b0001, 1'b0, 4'b0000);
    repeat (9) step(1'b0, 4'b0001, 4'b0001, 4'b0001, 1'b0, 4'b0000);
    // Three-cycle glitch on line 1 must be rejected.
    repeat (3) step(1'b0, 4'b0011, 4'b0011, 4'b0001, 1'b0, 4'b0000);
    repeat (8) step(1'b0, 4'b0001, 4'b0011, 4'b0001, 1'b0, 4'b0000);
    // Falling select on line 2: rise is ignored, fall is latched.
    repeat (9) step(1'b0, 4'b0101, 4'b1011, 4'b0001, 1'b0, 4'b0000);
    repeat (9) step(1'b0, 4'b0001, 4'b1011, 4'b0001, 1'b0, 4'b0000);
    // Mask and clear.
    repeat (3) step(1'b0, 4'b0001, 4'b1011, 4'b0000, 1'b0, 4'b0000);
    repeat (3) step(1'b0, 4'b0001, 4'b1011, 4'b0001, 1'b0, 4'b0000);
    step(1'b0, 4'b0001, 4'b1011, 4'b0001, 1'b1, 4'b0111);
    repeat (3) step(1'b0, 4'b0001, 4'b1011, 4'b0001, 1'b0, 4'b0000);
    // Clear every cycle while line 0 falls with a falling select: set must win.
    repeat (9) step(1'b0, 4'b0000, 4'b1010, 4'b0001, 1'b1, 4'b0001);
    repeat (3) step(1'b0, 4'b0000, 4'b1010, 4'b0001, 1'b0, 4'b0000);
    // Build pending=1010, then reset while line 3 is settling.
    repeat (9) step(1'b0, 4'b0010, 4'b1010, 4'b1111, 1'b0, 4'b0000);
    repeat (9) step(1'b0, 4'b0000, 4'b1000, 4'b1111, 1'b0, 4'b0000);
    repeat (9) step(1'b0, 4'b1000, 4'b1000, 4'b1111, 1'b0, 4'b0000);
    step(1'b0, 4'b0000, 4'b1000, 4'b1111, 1'b1, 4'b1111);
    repeat (4) step(1'b0, 4'b1000, 4'b1000, 4'b1111, 1'b0, 4'b0000);
    step(1'b1, 4'b1000, 4'b1000, 4'b1111, 1'b0, 4'b0000);
    repeat (10) step(1'b0, 4'b1000, 4'b1000, 4'b1111, 1'b0, 4'b0000);

    // Random phase: each line holds a level for 1..7 cycles so glitches and accepts mix.
    sw_cur = 4'b1000; er_cur = 4'b1000; msk_cur = 4'b1111;
    for (int i = 0; i < WIDTH; i++) hold[i] = 1;
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < WIDTH; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          sw_cur[i] = $urandom_range(1, 0) == 1;
          hold[i] = $urandom_range(7, 1);
        end
      end
      if ($urandom_range(15, 0) == 0) er_cur = 4'($urandom);
      if ($urandom_range(7, 0) == 0) msk_cur = 4'($urandom);
      cv_cur = $urandom_range(5, 0) == 0;
      cm_cur = 4'($urandom);
      step($urandom_range(299, 0) == 0, sw_cur, er_cur, msk_cur, cv_cur, cm_cur);
    end

    repeat (2) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
